dct_mac_accumulator: RTL and testbench



---
 rtl/dct_pkg.sv | 23 ++
 rtl/dct_mac_accumulator_if.sv | 31 +++
 rtl/seq_mult_core.sv | 63 ++++++
 rtl/dct_mac_accumulator.sv | 84 ++++++++
 tb/tb_dct_mac_accumulator.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dct_pkg.sv
// Shared types and constants for the DCT multiply-accumulate datapath.
//   dct_state_t : FSM encoding for dct_mac_accumulator
//   DCT_WIDTH   : default operand width
//   DCT_TAPS    : default products per output word
//   acc_width() : accumulator width that cannot wrap for TAPS full-scale products
package dct_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ACC  = 2'd2,
        DONE = 2'd3
    } dct_state_t;

    localparam int unsigned DCT_WIDTH = 16;
    localparam int unsigned DCT_TAPS  = 8;

    // Product is 2*width bits; summing taps of them needs clog2(taps) extra bits.
    function automatic int unsigned acc_width(input int unsigned width, input int unsigned taps);
        return 2 * width + $clog2(taps);
    endfunction

endpackage

// File: rtl/dct_mac_accumulator_if.sv
// Operand-pair input stream and dot-product output stream.
//   master : upstream/downstream side (drives operands, accepts results)
//   slave  : dct_mac_accumulator side
//   in_valid/in_ready/in_a/in_b       : operand pair handshake
//   out_valid/out_ready/out_data      : accumulated result handshake
interface dct_mac_accumulator_if
    import dct_pkg::*;
#(
    parameter int unsigned WIDTH     = DCT_WIDTH,
    parameter int unsigned ACC_WIDTH = acc_width(DCT_WIDTH, DCT_TAPS)
) ();

    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/seq_mult_core.sv
// Bit-serial shift-add unsigned multiplier, fixed WIDTH-cycle latency.
//   clk, rst_n : clock, async active-low reset
//   start      : latch a/b and begin (ignored while busy)
//   a, b       : multiplicand, multiplier
//   busy       : high for the WIDTH cycles of a multiply
//   done       : one-cycle pulse in the last busy cycle; product is final after it
//   product    : exact 2*WIDTH-bit result
module seq_mult_core
    import dct_pkg::*;
#(
    parameter int unsigned WIDTH = DCT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH);

    logic [PW-1:0]    mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [CW-1:0]    bit_q;

    // One multiplier bit per cycle; done is raised one cycle early so it
    // coincides with the final add and the caller sees the result next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            product  <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            bit_q    <= '0;
        end else begin
            done <= 1'b0;
            if (start && !busy) begin
                busy     <= 1'b1;
                bit_q    <= '0;
                mcand_q  <= PW'(a);
                mplier_q <= b;
                product  <= '0;
            end else if (busy) begin
                if (mplier_q[bit_q]) begin
                    product <= product + (mcand_q << bit_q);
                end
                bit_q <= bit_q + CW'(1);
                if (bit_q == CW'(WIDTH - 2)) begin
                    done <= 1'b1;
                end
                if (bit_q == CW'(WIDTH - 1)) begin
                    busy <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/dct_mac_accumulator.sv
// Multiply-accumulate stage: sums TAPS unsigned operand products into one
// dot-product word using the bit-serial seq_mult_core.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of dct_mac_accumulator_if (operand in, result out)
module dct_mac_accumulator
    import dct_pkg::*;
#(
    parameter int unsigned WIDTH = DCT_WIDTH,
    parameter int unsigned TAPS  = DCT_TAPS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dct_mac_accumulator_if.slave  bus
);

    localparam int unsigned ACC_W = acc_width(WIDTH, TAPS);
    localparam int unsigned TAP_W = $clog2(TAPS) + 1;

    dct_state_t         state_q;
    dct_state_t         state_d;
    logic [TAP_W-1:0]   tap_cnt_q;
    logic [ACC_W-1:0]   acc_q;
    logic               in_ready_q;
    logic               out_valid_q;

    logic               start_c;
    logic               mult_busy;
    logic               mult_done;
    logic [2*WIDTH-1:0] mult_product;

    // Input accepted only in IDLE; the core's own busy guard is redundant here.
    assign start_c = (state_q == IDLE) && bus.in_valid && !mult_busy;

    seq_mult_core #(.WIDTH(WIDTH)) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start_c),
        .a       (bus.in_a),
        .b       (bus.in_b),
        .busy    (mult_busy),
        .done    (mult_done),
        .product (mult_product)
    );

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start_c)   state_d = MUL;
            MUL:  if (mult_done) state_d = ACC;
            ACC:  state_d = (tap_cnt_q == TAP_W'(TAPS - 1)) ? DONE : IDLE;
            DONE: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, accumulator and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            tap_cnt_q   <= '0;
            acc_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d == IDLE);
            out_valid_q <= (state_d == DONE);
            if (state_q == ACC) begin
                acc_q     <= acc_q + ACC_W'(mult_product);
                tap_cnt_q <= tap_cnt_q + TAP_W'(1);
            end
            if (state_q == DONE && bus.out_ready) begin
                acc_q     <= '0;
                tap_cnt_q <= '0;
            end
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = acc_q;

endmodule

// File: tb/tb_dct_mac_accumulator.sv
// Directed testbench for dct_mac_accumulator (WIDTH=16, TAPS=8).
module tb_dct_mac_accumulator;
    import dct_pkg::*;

    localparam int unsigned W  = 16;
    localparam int unsigned T  = 8;
    localparam int unsigned AW = 35;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   compared = 0;
    int   failed   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dct_mac_accumulator_if #(.WIDTH(W), .ACC_WIDTH(AW)) bus ();

    dct_mac_accumulator #(.WIDTH(W), .TAPS(T)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Offer one pair as soon as in_ready; edge_t is the acceptance edge index.
    task automatic drive_pair(input logic [W-1:0] a, input logic [W-1:0] b,
                              output int edge_t, output bit ok);
        ok = 1'b0;
        edge_t = 0;
        for (int i = 0; i < 60; i++) begin
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            bus.in_valid = 1'b1;
            bus.in_a = a;
            bus.in_b = b;
            @(negedge clk);
            edge_t = cyc;
            bus.in_valid = 1'b0;
        end
    endtask

    // Wait (bounded) for out_valid; c is the edge count at the observing negedge.
    task automatic wait_out(output int c, output bit ok);
        ok = 1'b0;
        c = 0;
        for (int i = 0; i < 60; i++) begin
            if (bus.out_valid) begin
                ok = 1'b1;
                c = cyc;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        compared++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_data !== '0) begin
            failed++;
            $display("FAIL reset_hold: rdy=%b vld=%b data=%0h want 1 0 0",
                     bus.in_ready, bus.out_valid, bus.out_data);
        end
        rst_n = 1'b1;
        @(negedge clk);
        compared++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_data !== '0) begin
            failed++;
            $display("FAIL reset_release: rdy=%b vld=%b data=%0h want 1 0 0",
                     bus.in_ready, bus.out_valid, bus.out_data);
        end
    endtask

    task automatic test_ones;
        int t[8];
        int c;
        bit ok;
        bit all_ok = 1'b1;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            drive_pair(16'd1, 16'd1, t[k], ok);
            if (!ok) all_ok = 1'b0;
        end
        compared++;
        if (!all_ok) begin
            failed++;
            $display("FAIL ones_accept: in_ready timeout");
        end
        for (int k = 1; k < 8; k++) begin
            compared++;
            if (t[k] - t[k-1] != 18) begin
                failed++;
                $display("FAIL ones_gap%0d: got %0d want 18", k, t[k] - t[k-1]);
            end
        end
        wait_out(c, ok);
        compared++;
        if (!ok) begin
            failed++;
            $display("FAIL ones_out_timeout: out_valid never rose");
        end
        compared++;
        if (c + 1 - t[7] != 18) begin
            failed++;
            $display("FAIL ones_latency: got %0d want 18", c + 1 - t[7]);
        end
        compared++;
        if (bus.out_data !== 35'd8) begin
            failed++;
            $display("FAIL ones_sum: got %0h want 8", bus.out_data);
        end
        @(negedge clk);
        compared++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            failed++;
            $display("FAIL ones_release: vld=%b rdy=%b want 0 1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_max;
        int t;
        int c;
        bit ok;
        bit all_ok = 1'b1;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            drive_pair(16'hFFFF, 16'hFFFF, t, ok);
            if (!ok) all_ok = 1'b0;
        end
        wait_out(c, ok);
        compared++;
        if (!ok || !all_ok) begin
            failed++;
            $display("FAIL max_timeout: handshake stalled");
        end
        compared++;
        if (bus.out_data !== 35'h7_FFF0_0008) begin
            failed++;
            $display("FAIL max_sum: got %0h want 7fff00008", bus.out_data);
        end
        @(negedge clk);
    endtask

    task automatic test_hold_valid;
        int acc_cnt = 0;
        logic [AW-1:0] d0;
        bit stable = 1'b1;
        int t;
        int c;
        bit ok;
        bit all_ok = 1'b1;
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_a = 16'd0;
        bus.in_b = 16'd1;
        for (int i = 0; i < 400 && !bus.out_valid; i++) begin
            if (bus.in_ready) begin
                acc_cnt++;
                @(negedge clk);
                bus.in_a = W'(acc_cnt);
                bus.in_b = W'(acc_cnt + 1);
            end else begin
                @(negedge clk);
            end
        end
        compared++;
        if (bus.out_valid !== 1'b1) begin
            failed++;
            $display("FAIL hold_timeout: out_valid never rose");
        end
        compared++;
        if (acc_cnt != 8) begin
            failed++;
            $display("FAIL hold_accepts: got %0d want 8", acc_cnt);
        end
        compared++;
        if (bus.out_data !== 35'd168) begin
            failed++;
            $display("FAIL hold_sum: got %0d want 168", bus.out_data);
        end
        d0 = bus.out_data;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b1 || bus.out_data !== d0 || bus.in_ready !== 1'b0)
                stable = 1'b0;
        end
        compared++;
        if (!stable) begin
            failed++;
            $display("FAIL hold_stable: vld=%b data=%0d rdy=%b want 1 168 0",
                     bus.out_valid, bus.out_data, bus.in_ready);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        compared++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            failed++;
            $display("FAIL hold_release: vld=%b rdy=%b want 0 1", bus.out_valid, bus.in_ready);
        end
        for (int k = 0; k < 8; k++) begin
            drive_pair(16'd1, 16'd2, t, ok);
            if (!ok) all_ok = 1'b0;
        end
        wait_out(c, ok);
        compared++;
        if (!ok || !all_ok || bus.out_data !== 35'd16) begin
            failed++;
            $display("FAIL hold_next_frame: got %0d want 16", bus.out_data);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int t;
        int c;
        bit ok;
        bit all_ok = 1'b1;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            drive_pair(16'd1, 16'd1, t, ok);
            if (!ok) all_ok = 1'b0;
        end
        repeat (5) @(negedge clk);
        compared++;
        if (!all_ok || bus.in_ready !== 1'b0) begin
            failed++;
            $display("FAIL rst_mid_busy: rdy=%b want 0", bus.in_ready);
        end
        rst_n = 1'b0;
        #1;
        compared++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_data !== '0) begin
            failed++;
            $display("FAIL rst_mid_async: rdy=%b vld=%b data=%0h want 1 0 0",
                     bus.in_ready, bus.out_valid, bus.out_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        all_ok = 1'b1;
        for (int k = 0; k < 8; k++) begin
            drive_pair(16'd2, 16'd3, t, ok);
            if (!ok) all_ok = 1'b0;
        end
        wait_out(c, ok);
        compared++;
        if (!ok || !all_ok || bus.out_data !== 35'd48) begin
            failed++;
            $display("FAIL rst_mid_frame: got %0d want 48", bus.out_data);
        end
        @(negedge clk);
    endtask

    task automatic test_zero;
        int t[8];
        int c;
        bit ok;
        bit all_ok = 1'b1;
        logic [W-1:0] av[8] = '{16'h0000, 16'hFFFF, 16'd3, 16'd3, 16'd3, 16'd3, 16'd3, 16'd3};
        logic [W-1:0] bv[8] = '{16'hFFFF, 16'h0000, 16'd5, 16'd5, 16'd5, 16'd5, 16'd5, 16'd5};
        bus.out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            drive_pair(av[k], bv[k], t[k], ok);
            if (!ok) all_ok = 1'b0;
        end
        for (int k = 1; k < 3; k++) begin
            compared++;
            if (!all_ok || t[k] - t[k-1] != 18) begin
                failed++;
                $display("FAIL zero_gap%0d: got %0d want 18", k, t[k] - t[k-1]);
            end
        end
        wait_out(c, ok);
        compared++;
        if (!ok || c + 1 - t[7] != 18) begin
            failed++;
            $display("FAIL zero_latency: got %0d want 18", c + 1 - t[7]);
        end
        compared++;
        if (bus.out_data !== 35'd90) begin
            failed++;
            $display("FAIL zero_sum: got %0d want 90", bus.out_data);
        end
        @(negedge clk);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b1;
        rst_n         = 1'b0;
        test_reset();
        test_ones();
        test_max();
        test_hold_valid();
        test_reset_mid();
        test_zero();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
